// File: rtl/asteroid_wave_ctrl.sv
// Wave/level scheduler for the asteroid field: sizes each wave, issues per-quad spawn
// pulses, detects wave clear, waits the inter-wave delay and tracks the level in BCD.
module asteroid_wave_ctrl #(
    parameter int NQUAD        = 3,
    parameter int QUAD_START   = 1,
    parameter int DELAY_FRAMES = 90
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync,
    input  logic             game_begin,
    input  logic             game_over,
    input  logic [NQUAD-1:0] quad_alive,
    output logic [NQUAD-1:0] new_level,
    output logic [NQUAD-1:0] quad_active,
    output logic             wave_clear,
    output logic [7:0]       level_bcd,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPAWN = 2'd1,
        PLAY  = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t      state;
    logic [6:0]  level;
    logic [7:0]  delay_cnt;
    logic [6:0]  level_inc;
    logic [7:0]  bcd_inc;

    // Lowest K bits set, K = QUAD_START + lvl - 1; the loop bound caps K at NQUAD.
    function automatic logic [NQUAD-1:0] active_mask(input logic [6:0] lvl);
        int unsigned      k;
        logic [NQUAD-1:0] m;
        k = 32'(QUAD_START) + 32'(lvl) - 32'd1;
        m = '0;
        for (int unsigned i = 0; i < NQUAD; i++) begin
            if (i < k) m[i] = 1'b1;
        end
        return m;
    endfunction

    always_comb begin
        level_inc = (level == 7'd99) ? level : level + 7'd1;
        bcd_inc   = level_bcd;
        if (level_bcd != 8'h99) begin
            if (level_bcd[3:0] == 4'd9) bcd_inc = {level_bcd[7:4] + 4'd1, 4'd0};
            else                        bcd_inc = {level_bcd[7:4], level_bcd[3:0] + 4'd1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            level       <= '0;
            level_bcd   <= '0;
            quad_active <= '0;
            delay_cnt   <= '0;
            wave_clear  <= 1'b0;
        end else if (game_over) begin
            // Level is deliberately kept so the HUD shows the final level.
            state       <= IDLE;
            quad_active <= '0;
            delay_cnt   <= '0;
            wave_clear  <= 1'b0;
        end else begin
            wave_clear <= 1'b0;
            if (vsync) begin
                case (state)
                    IDLE: begin
                        if (game_begin) begin
                            level       <= 7'd1;
                            level_bcd   <= 8'h01;
                            quad_active <= active_mask(7'd1);
                            state       <= SPAWN;
                        end
                    end
                    SPAWN: state <= PLAY;
                    PLAY: begin
                        if ((quad_alive & quad_active) == '0) begin
                            wave_clear <= 1'b1;
                            delay_cnt  <= 8'(DELAY_FRAMES - 1);
                            state      <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (delay_cnt == '0) begin
                            level       <= level_inc;
                            level_bcd   <= bcd_inc;
                            quad_active <= active_mask(level_inc);
                            state       <= SPAWN;
                        end else begin
                            delay_cnt <= delay_cnt - 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Combinational so the pulse lands on the same vsync the quads sample.
    assign new_level = {NQUAD{vsync & (state == SPAWN) & ~game_over}} & quad_active;
    assign state_dbg = state;

endmodule
